// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_pkg
//  Description : Shared types and constants for the bit-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    // Control states of the serial subtractor
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest operand width the block is characterised for
    localparam int MAX_WIDTH = 32;

endpackage : sub_pkg
`default_nettype wire

// File: rtl/full_subtractor_bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor_bit
//  Description : Combinational 1-bit full subtractor (x - y - bin), built as
//                two cascaded half-subtractor stages with OR-ed borrows.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // First half-subtractor stage: x - y
    logic hs1_d;
    logic hs1_b;
    assign hs1_d = x ^ y;
    assign hs1_b = ~x & y;

    // Second half-subtractor stage: (x - y) - bin
    logic hs2_b;
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    // Either stage can generate the outgoing borrow, never both at once
    assign bout = hs1_b | hs2_b;

endmodule : full_subtractor_bit
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor, diff = a - b, LSB first,
//                one bit per clock. Parallel load on start, parallel result
//                with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject out-of-range widths at elaboration
    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("serial_subtractor: WIDTH out of range 1..32");
        end
    endgenerate

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               bin_q;
    logic [CNT_W-1:0]   cnt;

    logic               cell_d;
    logic               cell_bout;
    // Diff shift register contents after this edge's bit is shifted in
    logic [WIDTH-1:0]   d_next;

    full_subtractor_bit u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (bin_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // The diff shift register only has to remember WIDTH-1 earlier bits; the
    // newest bit comes straight from the cell on the final edge.
    generate
        if (WIDTH == 1) begin : g_d_w1
            assign d_next = cell_d;
        end else begin : g_d_wn
            logic [WIDTH-2:0] d_sr;

            assign d_next = {cell_d, d_sr};

            // Shift each computed bit in from the MSB side while running
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d_sr <= '0;
                end else if (state == RUN) begin
                    d_sr <= d_next[WIDTH-1:1];
                end
            end
        end
    endgenerate

    // Control FSM, operand shifters, borrow chain and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bin_q <= 1'b0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    bin_q <= cell_bout;
                    if (cnt == LAST_CNT) begin
                        diff   <= d_next;
                        borrow <= cell_bout;
                        busy   <= 1'b0;
                        ready  <= 1'b1;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Back-to-back reload with no idle gap
                        a_sr  <= a;
                        b_sr  <= b;
                        bin_q <= 1'b0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_subtractor
`default_nettype wire
